// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage widths and load-type encodings for the pipeline slice.
// Sub-word load extraction is compiled in only when MS_LOAD_EXT_EN is defined.
package mem_stage_pkg;
  localparam int ES_TO_MS_BUS_WD = 74;
  localparam int MS_TO_WS_BUS_WD = 70;
  localparam int MS_TO_DS_FWD_WD = 38;
  localparam int DATA_W          = 32;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_H  = 3'b010,
    LD_BU = 3'b011,
    LD_HU = 3'b100
  } ld_type_e;
endpackage

// File: rtl/mem_stage_ld_align.sv
// Byte/halfword select and sign/zero extension of the SRAM load word.
// Sub-word paths exist only under MS_LOAD_EXT_EN; otherwise every load is a full word.
module mem_ld_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        addr,
  input  logic [2:0]        ld_type,
  output logic [DATA_W-1:0] value
);

`ifdef MS_LOAD_EXT_EN
  function automatic logic signed [DATA_W-1:0] sext8(input logic signed [7:0] v);
    return v;
  endfunction

  function automatic logic signed [DATA_W-1:0] sext16(input logic signed [15:0] v);
    return v;
  endfunction

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = rdata[8*addr +: 8];
    ld_half = addr[1] ? rdata[31:16] : rdata[15:0];
    case (ld_type)
      LD_B:    value = sext8(ld_byte);
      LD_BU:   value = {{(DATA_W-8){1'b0}}, ld_byte};
      LD_H:    value = sext16(ld_half);
      LD_HU:   value = {{(DATA_W-16){1'b0}}, ld_half};
      default: value = rdata;
    endcase
  end
`else
  logic unused_sel;
  assign unused_sel = ^{addr, ld_type};
  assign value      = rdata;
`endif

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches execute's bus, holds SRAM read data across
// writeback stalls, aligns loads and drives writeback and forwarding buses.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_TO_DS_FWD_WD-1:0] ms_to_ds_fwd_bus,
  input  logic [DATA_W-1:0]          data_sram_rdata
);

  logic                       ms_valid;
  logic                       ms_ready_go;
  logic [ES_TO_MS_BUS_WD-1:0] ms_bus_r;
  logic                       buf_valid;
  logic [DATA_W-1:0]          rdata_buf;

  logic [2:0]        ms_ld_type;
  logic              ms_res_from_mem;
  logic              ms_gr_we;
  logic [4:0]        ms_dest;
  logic [DATA_W-1:0] ms_alu_result;
  logic [DATA_W-1:0] ms_pc;
  logic [DATA_W-1:0] ld_word;
  logic [DATA_W-1:0] ld_value;
  logic [DATA_W-1:0] final_result;
  logic              buf_capture;
  logic              ms_leave;

  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;

  assign ms_leave    = ms_to_ws_valid && ws_allowin;
  assign buf_capture = ms_valid && !ws_allowin && !buf_valid;

  // Stage boundary: execute -> mem (control)
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid  <= 1'b0;
      buf_valid <= 1'b0;
    end else begin
      if (ms_allowin) ms_valid <= es_to_ms_valid;
      if (ms_leave)         buf_valid <= 1'b0;
      else if (buf_capture) buf_valid <= 1'b1;
    end
  end

  // Data registers are don't-care while their valid flag is low
  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) ms_bus_r <= es_to_ms_bus;
    if (buf_capture) rdata_buf <= data_sram_rdata;
  end

  assign {ms_ld_type, ms_res_from_mem, ms_gr_we, ms_dest, ms_alu_result, ms_pc} = ms_bus_r;

  assign ld_word = buf_valid ? rdata_buf : data_sram_rdata;

  mem_ld_align #(.DATA_W(DATA_W)) u_ld_align (
    .rdata   (ld_word),
    .addr    (ms_alu_result[1:0]),
    .ld_type (ms_ld_type),
    .value   (ld_value)
  );

  assign final_result     = ms_res_from_mem ? ld_value : ms_alu_result;
  assign ms_to_ws_bus     = {ms_gr_we, ms_dest, final_result, ms_pc};
  assign ms_to_ds_fwd_bus = {ms_valid && ms_gr_we && (ms_dest != 5'd0), ms_dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, loads, extension, stall hold,
// forwarding, back-to-back flow and reset during a stall.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                       clk;
  logic                       reset;
  logic                       ws_allowin;
  logic                       ms_allowin;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [MS_TO_DS_FWD_WD-1:0] ms_to_ds_fwd_bus;
  logic [31:0]                data_sram_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  mem_stage dut (
    .clk              (clk),
    .reset            (reset),
    .ws_allowin       (ws_allowin),
    .ms_allowin       (ms_allowin),
    .es_to_ms_valid   (es_to_ms_valid),
    .es_to_ms_bus     (es_to_ms_bus),
    .ms_to_ws_valid   (ms_to_ws_valid),
    .ms_to_ws_bus     (ms_to_ws_bus),
    .ms_to_ds_fwd_bus (ms_to_ds_fwd_bus),
    .data_sram_rdata  (data_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [73:0] mk_bus(input logic [2:0] ld, input logic rfm, input logic we,
                                         input logic [4:0] dest, input logic [31:0] alu,
                                         input logic [31:0] pc);
    return {ld, rfm, we, dest, alu, pc};
  endfunction

  // Present one instruction, let it be accepted, then drive the SRAM data for it
  task automatic send(input logic [73:0] bus, input logic [31:0] rdata);
    @(posedge clk); #1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = bus;
    @(posedge clk); #1;
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = rdata;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; ws_allowin = 1'b1; es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0; data_sram_rdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (ms_to_ws_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", ms_to_ws_valid);
    else n_pass++;
    n_checks++;
    if (ms_to_ds_fwd_bus[37] !== 1'b0) $display("FAIL reset_fwd got=%b want=0", ms_to_ds_fwd_bus[37]);
    else n_pass++;
    n_checks++;
    if (ms_allowin !== 1'b1) $display("FAIL reset_allowin got=%b want=1", ms_allowin);
    else n_pass++;
  endtask

  task automatic test_load_word;
    ws_allowin = 1'b1;
    send(mk_bus(3'b000, 1'b1, 1'b1, 5'd4, 32'h1000, 32'h100), 32'hDEADBEEF);
    n_checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'hDEADBEEF || ms_to_ws_bus[31:0] !== 32'h100)
      $display("FAIL ldw v=%b res=%h pc=%h want v=1 res=deadbeef pc=100",
               ms_to_ws_valid, ms_to_ws_bus[63:32], ms_to_ws_bus[31:0]);
    else n_pass++;
    @(posedge clk); #2;
    n_checks++;
    if (ms_to_ws_valid !== 1'b0) $display("FAIL ldw_drain got=%b want=0", ms_to_ws_valid);
    else n_pass++;
  endtask

  task automatic test_extension;
    logic [2:0]  lt  [4] = '{3'b001, 3'b011, 3'b010, 3'b100};
    logic [31:0] ad  [4] = '{32'h2002, 32'h2003, 32'h2002, 32'h2000};
`ifdef MS_LOAD_EXT_EN
    logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
`else
    logic [31:0] exp [4] = '{32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01};
`endif
    ws_allowin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(mk_bus(lt[i], 1'b1, 1'b1, 5'd6, ad[i], 32'h300 + 32'(4*i)), 32'h80FF7F01);
      n_checks++;
      if (ms_to_ws_bus[63:32] !== exp[i])
        $display("FAIL ext_%0d got=%h want=%h", i, ms_to_ws_bus[63:32], exp[i]);
      else n_pass++;
    end
    @(posedge clk); #2;
  endtask

  task automatic test_stall;
    ws_allowin = 1'b0;
    send(mk_bus(3'b000, 1'b1, 1'b1, 5'd7, 32'h4000, 32'h400), 32'h12345678);
    @(posedge clk); #1;
    data_sram_rdata = 32'hAAAAAAAA;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (ms_to_ws_bus[63:32] !== 32'h12345678 || ms_allowin !== 1'b0 || ms_to_ws_valid !== 1'b1)
        $display("FAIL stall_%0d res=%h allowin=%b v=%b want res=12345678 allowin=0 v=1",
                 i, ms_to_ws_bus[63:32], ms_allowin, ms_to_ws_valid);
      else n_pass++;
      @(posedge clk); #1;
    end
    ws_allowin = 1'b1;
    #1;
    n_checks++;
    if (ms_to_ws_bus[63:32] !== 32'h12345678 || ms_allowin !== 1'b1)
      $display("FAIL stall_release res=%h allowin=%b want res=12345678 allowin=1",
               ms_to_ws_bus[63:32], ms_allowin);
    else n_pass++;
    @(posedge clk); #2;
    n_checks++;
    if (dut.buf_valid !== 1'b0 || ms_to_ws_valid !== 1'b0)
      $display("FAIL stall_bufclr buf=%b v=%b want 0 0", dut.buf_valid, ms_to_ws_valid);
    else n_pass++;
  endtask

  task automatic test_forward;
    ws_allowin = 1'b1;
    send(mk_bus(3'b000, 1'b0, 1'b1, 5'd5, 32'h42, 32'h500), 32'hCAFEF00D);
    n_checks++;
    if (ms_to_ds_fwd_bus !== {1'b1, 5'd5, 32'h42})
      $display("FAIL fwd_add got=%h want=%h", ms_to_ds_fwd_bus, {1'b1, 5'd5, 32'h42});
    else n_pass++;
    send(mk_bus(3'b000, 1'b0, 1'b1, 5'd0, 32'h42, 32'h504), 32'hCAFEF00D);
    n_checks++;
    if (ms_to_ds_fwd_bus[37] !== 1'b0 || ms_to_ws_valid !== 1'b1)
      $display("FAIL fwd_dest0 fwd=%b v=%b want fwd=0 v=1", ms_to_ds_fwd_bus[37], ms_to_ws_valid);
    else n_pass++;
    send(mk_bus(3'b000, 1'b0, 1'b0, 5'd9, 32'h77, 32'h508), 32'hCAFEF00D);
    n_checks++;
    if (ms_to_ds_fwd_bus[37] !== 1'b0 || ms_to_ws_bus[69] !== 1'b0)
      $display("FAIL fwd_nowe fwd=%b we=%b want 0 0", ms_to_ds_fwd_bus[37], ms_to_ws_bus[69]);
    else n_pass++;
    @(posedge clk); #2;
  endtask

  task automatic test_back_to_back;
    ws_allowin = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk_bus(3'b000, 1'b0, 1'b1, 5'd3, 32'(i), 32'h600 + 32'(4*i));
      @(posedge clk); #1;
      n_checks++;
      if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[31:0] !== 32'h600 + 32'(4*i) ||
          ms_to_ws_bus[63:32] !== 32'(i) || ms_allowin !== 1'b1)
        $display("FAIL b2b_%0d v=%b pc=%h res=%h allowin=%b want v=1 pc=%h res=%h allowin=1",
                 i, ms_to_ws_valid, ms_to_ws_bus[31:0], ms_to_ws_bus[63:32], ms_allowin,
                 32'h600 + 32'(4*i), 32'(i));
      else n_pass++;
    end
    es_to_ms_valid = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic test_reset_mid_stall;
    ws_allowin = 1'b0;
    send(mk_bus(3'b000, 1'b1, 1'b1, 5'd8, 32'h7000, 32'h700), 32'h11111111);
    @(posedge clk); #1;
    data_sram_rdata = 32'h22222222;
    n_checks++;
    if (dut.buf_valid !== 1'b1) $display("FAIL rst_stall_buf got=%b want=1", dut.buf_valid);
    else n_pass++;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1 || ms_to_ds_fwd_bus[37] !== 1'b0)
      $display("FAIL rst_stall v=%b allowin=%b fwd=%b want 0 1 0",
               ms_to_ws_valid, ms_allowin, ms_to_ds_fwd_bus[37]);
    else n_pass++;
    ws_allowin = 1'b1;
    send(mk_bus(3'b000, 1'b1, 1'b1, 5'd8, 32'h7004, 32'h704), 32'h33333333);
    n_checks++;
    if (ms_to_ws_bus[63:32] !== 32'h33333333)
      $display("FAIL rst_stall_live got=%h want=33333333", ms_to_ws_bus[63:32]);
    else n_pass++;
    @(posedge clk); #2;
  endtask

  initial begin
    test_reset;
    test_load_word;
    test_extension;
    test_stall;
    test_forward;
    test_back_to_back;
    test_reset_mid_stall;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
